// File: rtl/lm_pkg.sv
// Shared slot ids, FSM encoding and channel helpers for the LED display scheduler.
// Pure declarations, no latency; no flow control.
package lm_pkg;

    localparam int NUM_CH = 3;

    localparam logic [1:0] SLOT_IDLE  = 2'b00;
    localparam logic [1:0] SLOT_CM    = 2'b01;
    localparam logic [1:0] SLOT_UERR  = 2'b10;
    localparam logic [1:0] SLOT_UDATA = 2'b11;

    localparam logic [1:0] CH_CM    = 2'd0;
    localparam logic [1:0] CH_UERR  = 2'd1;
    localparam logic [1:0] CH_UDATA = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    function automatic logic [1:0] ch_next(input logic [1:0] ch);
        return (ch >= CH_UDATA) ? CH_CM : ch + 2'd1;
    endfunction

    function automatic logic [NUM_CH-1:0] ch_mask(input logic [1:0] ch);
        logic [NUM_CH-1:0] m;
        case (ch)
            CH_CM:    m = 3'b001;
            CH_UERR:  m = 3'b010;
            CH_UDATA: m = 3'b100;
            default:  m = 3'b000;
        endcase
        return m;
    endfunction

    function automatic logic [1:0] slot_of(input logic [1:0] ch);
        return ch + 2'd1;
    endfunction

endpackage

// File: rtl/lm_rr_pick.sv
// Round-robin pick: first set pending bit searching ptr, ptr+1, ptr+2 (mod 3).
// Purely combinational; no flow control.
module lm_rr_pick
    import lm_pkg::*;
(
    input  logic [NUM_CH-1:0] pending_i,
    input  logic [1:0]        ptr_i,
    output logic [1:0]        grant_o,
    output logic              any_o
);

    logic [1:0] idx;

    always_comb begin
        grant_o = CH_CM;
        any_o   = 1'b0;
        idx     = (ptr_i > CH_UDATA) ? CH_CM : ptr_i;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!any_o && ((pending_i & ch_mask(idx)) != '0)) begin
                grant_o = idx;
                any_o   = 1'b1;
            end
            idx = ch_next(idx);
        end
    end

endmodule

// File: rtl/lm_display_scheduler.sv
// Round-robin time-slicing of CM error / UART error / UART data words onto one LED bank (blink: LM_BLINK_EN).
// Latency: strobe at edge N is latched at N, shown at N+1 when idle; each slot holds HOLD_CYCLES.
// No backpressure: a strobe on a still-pending channel overwrites it and raises the sticky overflow bit.
module lm_display_scheduler
    import lm_pkg::*;
#(
    parameter int WIDTH_LEDS       = 16,
    parameter int WIDTH_UART_DATA  = 8,
    parameter int WIDTH_UART_ERROR = 4,
    parameter int WIDTH_VGA_ERROR  = 4,
    parameter int HOLD_CYCLES      = 50000000,
    parameter int BLINK_HALF       = 12500000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        UART_data_debug_switch,
    input  logic [WIDTH_VGA_ERROR-1:0]  CM_errors,
    input  logic                        CM_errors_valid,
    input  logic [WIDTH_UART_ERROR-1:0] UART_errors,
    input  logic                        UART_errors_valid,
    input  logic [WIDTH_UART_DATA-1:0]  UART_data,
    input  logic                        UART_data_valid,
    input  logic                        clr_overflow,
    output logic [WIDTH_LEDS-1:0]       leds,
    output logic [1:0]                  active_slot,
    output logic                        busy,
    output logic [2:0]                  overflow
);

    localparam int          PW        = WIDTH_LEDS - 2;
    localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);

    if (HOLD_CYCLES < 2 || BLINK_HALF < 1 || PW < WIDTH_UART_DATA ||
        PW < WIDTH_UART_ERROR || PW < WIDTH_VGA_ERROR) begin : g_param_check
        $error("lm_display_scheduler: illegal parameter combination");
    end

    state_t                      state_q, state_d;
    logic [1:0]                  cur_q, cur_d;
    logic [1:0]                  rr_ptr_q, rr_ptr_d;
    logic [31:0]                 cnt_q, cnt_d;
    logic [PW-1:0]               snap_q, snap_d;
    logic                        fresh_q, fresh_d;
    logic [NUM_CH-1:0]           pend_q, pend_d;
    logic [NUM_CH-1:0]           ovf_q, ovf_d;
    logic [WIDTH_VGA_ERROR-1:0]  cm_q, cm_d;
    logic [WIDTH_UART_ERROR-1:0] uerr_q, uerr_d;
    logic [WIDTH_UART_DATA-1:0]  udata_q, udata_d;
    logic [WIDTH_LEDS-1:0]       leds_q, leds_d;
    logic [1:0]                  slot_q, slot_d;

    logic [NUM_CH-1:0] vld, cur_mask, shown;
    logic [NUM_CH-1:0] pick_req;
    logic [1:0]        pick_ptr, pick_ch;
    logic              pick_any;
    logic              expire, load, vld_cur, blink_on;
    logic [PW-1:0]     pick_pay, out_pay;

    assign vld      = {UART_data_valid, UART_errors_valid, CM_errors_valid};
    assign cur_mask = ch_mask(cur_q);
    assign shown    = (state_q == ST_SHOW) ? cur_mask : '0;
    assign vld_cur  = (vld & cur_mask) != '0;

    // Expiry search skips the channel just shown and starts after it.
    assign pick_req = (state_q == ST_SHOW) ? (pend_q & ~cur_mask) : pend_q;
    assign pick_ptr = (state_q == ST_SHOW) ? ch_next(cur_q) : rr_ptr_q;

    lm_rr_pick u_pick (
        .pending_i (pick_req),
        .ptr_i     (pick_ptr),
        .grant_o   (pick_ch),
        .any_o     (pick_any)
    );

    always_comb begin
        case (pick_ch)
            CH_CM:   pick_pay = PW'(cm_q);
            CH_UERR: pick_pay = PW'(uerr_q);
            default: pick_pay = PW'(udata_q);
        endcase
    end

    // Capture, pending and sticky overflow bookkeeping.
    always_comb begin : capture
        cm_d    = CM_errors_valid   ? CM_errors   : cm_q;
        uerr_d  = UART_errors_valid ? UART_errors : uerr_q;
        udata_d = UART_data_valid   ? UART_data   : udata_q;
        ovf_d   = (clr_overflow ? '0 : ovf_q) | (vld & pend_q & ~shown);
        pend_d  = pend_q | vld;
        if (expire && !(fresh_q || vld_cur)) begin
            pend_d = pend_d & ~cur_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin : state_reg
        if (rst) begin
            state_q  <= ST_IDLE;
            cur_q    <= CH_CM;
            rr_ptr_q <= CH_CM;
            cnt_q    <= '0;
            snap_q   <= '0;
            fresh_q  <= 1'b0;
            pend_q   <= '0;
            ovf_q    <= '0;
            cm_q     <= '0;
            uerr_q   <= '0;
            udata_q  <= '0;
            leds_q   <= '0;
            slot_q   <= SLOT_IDLE;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            snap_q   <= snap_d;
            fresh_q  <= fresh_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            cm_q     <= cm_d;
            uerr_q   <= uerr_d;
            udata_q  <= udata_d;
            leds_q   <= leds_d;
            slot_q   <= slot_d;
        end
    end

    // fresh_q remembers a newer word for the shown channel so expiry keeps it pending.
    always_comb begin : next_state
        state_d  = state_q;
        cur_d    = cur_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        snap_d   = snap_q;
        fresh_d  = fresh_q;
        expire   = 1'b0;
        load     = 1'b0;
        if (!UART_data_debug_switch) begin
            case (state_q)
                ST_IDLE: load = pick_any;
                ST_SHOW: begin
                    fresh_d = fresh_q | vld_cur;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 32'd1;
                    end else begin
                        expire   = 1'b1;
                        rr_ptr_d = ch_next(cur_q);
                        load     = pick_any;
                        state_d  = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (load) begin
                state_d = ST_SHOW;
                cur_d   = pick_ch;
                cnt_d   = HOLD_LAST;
                snap_d  = pick_pay;
                fresh_d = (vld & ch_mask(pick_ch)) != '0;
            end
        end else if (state_q == ST_SHOW) begin
            fresh_d = fresh_q | vld_cur;
        end
    end

`ifdef LM_BLINK_EN
    localparam logic [31:0] BLINK_LAST = 32'(BLINK_HALF - 1);

    logic        phase_q, phase_d;
    logic [31:0] bcnt_q, bcnt_d;

    always_comb begin
        phase_d = phase_q;
        bcnt_d  = bcnt_q;
        if (load) begin
            phase_d = 1'b1;
            bcnt_d  = BLINK_LAST;
        end else if (state_q == ST_SHOW && !UART_data_debug_switch) begin
            if (bcnt_q == '0) begin
                phase_d = ~phase_q;
                bcnt_d  = BLINK_LAST;
            end else begin
                bcnt_d = bcnt_q - 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= 1'b1;
            bcnt_q  <= '0;
        end else begin
            phase_q <= phase_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign blink_on = phase_d;
`else
    assign blink_on = 1'b1;
`endif

    always_comb begin : outputs
        leds_d  = '0;
        slot_d  = SLOT_IDLE;
        out_pay = snap_d;
        if (cur_d != CH_UDATA && !blink_on) begin
            out_pay = '0;
        end
        if (UART_data_debug_switch) begin
            slot_d = SLOT_UDATA;
            leds_d = {SLOT_UDATA, PW'(udata_d)};
        end else if (state_d == ST_SHOW) begin
            slot_d = slot_of(cur_d);
            leds_d = {slot_of(cur_d), out_pay};
        end
    end

    assign leds        = leds_q;
    assign active_slot = slot_q;
    assign busy        = (state_q == ST_SHOW);
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_lm_display_scheduler.sv
// Directed bench with a slot-level reference model checked every negedge, plus literal spot checks.
module tb_lm_display_scheduler;

    localparam int HOLD  = 8;
    localparam int BHALF = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        dbg_sw;
    logic [3:0]  cm_err;
    logic        cm_vld;
    logic [3:0]  u_err;
    logic        u_err_vld;
    logic [7:0]  u_dat;
    logic        u_dat_vld;
    logic        clr_ovf;
    logic [15:0] leds;
    logic [1:0]  active_slot;
    logic        busy;
    logic [2:0]  overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lm_display_scheduler #(
        .WIDTH_LEDS       (16),
        .WIDTH_UART_DATA  (8),
        .WIDTH_UART_ERROR (4),
        .WIDTH_VGA_ERROR  (4),
        .HOLD_CYCLES      (HOLD),
        .BLINK_HALF       (BHALF)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .UART_data_debug_switch (dbg_sw),
        .CM_errors              (cm_err),
        .CM_errors_valid        (cm_vld),
        .UART_errors            (u_err),
        .UART_errors_valid      (u_err_vld),
        .UART_data              (u_dat),
        .UART_data_valid        (u_dat_vld),
        .clr_overflow           (clr_ovf),
        .leds                   (leds),
        .active_slot            (active_slot),
        .busy                   (busy),
        .overflow               (overflow)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h required=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: which slot is on screen, how many display cycles remain, what is queued.
    bit [2:0]    m_pend, m_ovf;
    int          m_pay[3];
    bit          m_show, m_fresh;
    int          m_cur, m_left, m_k, m_rr, m_snap;
    logic [15:0] m_leds;
    logic [1:0]  m_slot;

    function automatic int pick(input bit [2:0] p, input int rr);
        for (int k = 0; k < 3; k++) begin
            if (p[(rr + k) % 3]) return (rr + k) % 3;
        end
        return -1;
    endfunction

    task automatic m_start(input int c, input int pay, input bit same_vld);
        m_show  = 1'b1;
        m_cur   = c;
        m_left  = HOLD;
        m_k     = 0;
        m_snap  = pay;
        m_fresh = same_vld;
    endtask

    task automatic m_reset();
        m_pend = '0; m_ovf = '0; m_show = 1'b0; m_fresh = 1'b0;
        m_cur = 0; m_left = 0; m_k = 0; m_rr = 0; m_snap = 0;
        for (int i = 0; i < 3; i++) m_pay[i] = 0;
        m_leds = '0; m_slot = '0;
    endtask

    task automatic m_step();
        bit [2:0] v, old_pend;
        int       in_pay[3];
        int       old_pay[3];
        int       c, pay;
        v = {u_dat_vld, u_err_vld, cm_vld};
        in_pay[0] = int'(cm_err);
        in_pay[1] = int'(u_err);
        in_pay[2] = int'(u_dat);
        old_pend = m_pend;
        old_pay  = m_pay;
        if (clr_ovf) m_ovf = '0;
        for (int i = 0; i < 3; i++) begin
            if (v[i]) begin
                if (old_pend[i] && !(m_show && m_cur == i)) m_ovf[i] = 1'b1;
                m_pend[i] = 1'b1;
                m_pay[i]  = in_pay[i];
            end
        end
        if (!dbg_sw) begin
            if (!m_show) begin
                c = pick(old_pend, m_rr);
                if (c >= 0) m_start(c, old_pay[c], v[c]);
            end else if (m_left > 1) begin
                m_left--;
                m_k++;
                if (v[m_cur]) m_fresh = 1'b1;
            end else begin
                if (!(m_fresh || v[m_cur])) m_pend[m_cur] = 1'b0;
                m_rr = (m_cur + 1) % 3;
                old_pend[m_cur] = 1'b0;
                c = pick(old_pend, m_rr);
                if (c >= 0) m_start(c, old_pay[c], v[c]);
                else m_show = 1'b0;
            end
        end else if (m_show && v[m_cur]) begin
            m_fresh = 1'b1;
        end
        if (dbg_sw) begin
            m_slot = 2'b11;
            m_leds = {2'b11, 14'(m_pay[2])};
        end else if (m_show) begin
            pay = m_snap;
`ifdef LM_BLINK_EN
            if (m_cur != 2 && ((m_k / BHALF) % 2) == 1) pay = 0;
`endif
            m_slot = 2'(m_cur + 1);
            m_leds = {m_slot, 14'(pay)};
        end else begin
            m_slot = 2'b00;
            m_leds = '0;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else m_step();
    end

    always @(negedge clk) begin
        chk("model_leds", 32'(leds), 32'(m_leds));
        chk("model_slot", 32'(active_slot), 32'(m_slot));
        chk("model_busy", 32'(busy), 32'(m_show));
        chk("model_ovf", 32'(overflow), 32'(m_ovf));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; dbg_sw = 1'b0; clr_ovf = 1'b0;
        cm_err = '0; cm_vld = 1'b0; u_err = '0; u_err_vld = 1'b0; u_dat = '0; u_dat_vld = 1'b0;
        repeat (2) step();
        chk("rst_leds", 32'(leds), 32'h0);
        chk("rst_slot", 32'(active_slot), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        rst = 1'b0;
        step();

        // Single CM error: two edges to display, eight cycles on screen.
        cm_err = 4'hA; cm_vld = 1'b1;
        step();
        cm_vld = 1'b0;
        chk("t1_not_yet", 32'(leds), 32'h0);
        step();
        chk("t1_leds", 32'(leds), 32'h400A);
        chk("t1_slot", 32'(active_slot), 32'h1);
        chk("t1_busy", 32'(busy), 32'h1);
        repeat (7) step();
        chk("t1_last", 32'(leds), 32'h400A);
        step();
        chk("t1_end_leds", 32'(leds), 32'h0);
        chk("t1_end_busy", 32'(busy), 32'h0);

        // All three at once: 01, 10, 11 back to back.
        do_reset();
        cm_err = 4'h3; u_err = 4'h6; u_dat = 8'h81;
        cm_vld = 1'b1; u_err_vld = 1'b1; u_dat_vld = 1'b1;
        step();
        cm_vld = 1'b0; u_err_vld = 1'b0; u_dat_vld = 1'b0;
        step();
        chk("t2_cm", 32'(leds), 32'h4003);
        repeat (8) step();
        chk("t2_uerr", 32'(leds), 32'h8006);
        repeat (8) step();
        chk("t2_udata", 32'(leds), 32'hC081);
        repeat (8) step();
        chk("t2_idle", 32'(leds), 32'h0);

        // Overflow on UART errors while the CM slot is on screen.
        do_reset();
        cm_err = 4'h9; cm_vld = 1'b1;
        step();
        cm_vld = 1'b0;
        step();
        u_err = 4'h3; u_err_vld = 1'b1;
        step();
        u_err = 4'h5;
        step();
        u_err_vld = 1'b0;
        chk("t3_ovf", 32'(overflow), 32'h2);
        repeat (6) step();
        chk("t3_uerr", 32'(leds), 32'h8005);
        chk("t3_slot", 32'(active_slot), 32'h2);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("t3_clr", 32'(overflow), 32'h0);

        // Debug bypass mid-slot at count 4.
        do_reset();
        cm_err = 4'h7; cm_vld = 1'b1;
        step();
        cm_vld = 1'b0;
        step();
        repeat (3) step();
        dbg_sw = 1'b1; u_dat = 8'h5C; u_dat_vld = 1'b1;
        step();
        u_dat_vld = 1'b0;
        chk("t4_dbg_leds", 32'(leds), 32'hC05C);
        chk("t4_dbg_slot", 32'(active_slot), 32'h3);
        chk("t4_dbg_busy", 32'(busy), 32'h1);
        repeat (2) step();
        dbg_sw = 1'b0;
        step();
        chk("t4_resume", 32'(leds), 32'h4007);
        repeat (3) step();
        chk("t4_last", 32'(leds), 32'h4007);
        step();
        chk("t4_next", 32'(leds), 32'hC05C);

        // Reset in the middle of a slot drops everything.
        do_reset();
        cm_err = 4'h1; u_err = 4'h2; cm_vld = 1'b1; u_err_vld = 1'b1;
        step();
        cm_vld = 1'b0; u_err_vld = 1'b0;
        step();
        repeat (2) step();
        rst = 1'b1;
        #1;
        chk("t5_rst_leds", 32'(leds), 32'h0);
        chk("t5_rst_busy", 32'(busy), 32'h0);
        step();
        rst = 1'b0;
        repeat (20) step();
        chk("t5_after_leds", 32'(leds), 32'h0);
        chk("t5_after_busy", 32'(busy), 32'h0);

`ifdef LM_BLINK_EN
        do_reset();
        u_err = 4'hF; u_err_vld = 1'b1;
        step();
        u_err_vld = 1'b0;
        step();
        for (int k = 0; k < 8; k++) begin
            chk("t6_blink", 32'(leds), ((k % 4) < 2) ? 32'h800F : 32'h8000);
            step();
        end
`endif

        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
